// File: rtl/instr_issue.sv
// Fetch/issue sequencer: fetches one 16-bit instruction at a time, splits it into fields and
// hands it to decode over valid/ready, stalling after a BEZ until execute resolves the branch.
module instr_issue #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [15:0]      imem_rdata,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [3:0]       iss_opcode,
  output logic [3:0]       iss_rd,
  output logic [3:0]       iss_rs,
  output logic [3:0]       iss_rt,
  output logic [PC_W-1:0]  iss_pc,
  output logic             iss_illegal,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {StFetch, StWait, StIssue, StBranch} state_e;

  localparam logic [3:0] OpBez = 4'b1011;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  iss_pc_q;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             ir_legal;
  logic             ir_is_bez;

  always_comb begin
    ir_legal = 1'b0;
    case (ir_q[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: ir_legal = 1'b1;
      default:                                                   ir_legal = 1'b0;
    endcase
  end

  assign ir_is_bez = ir_legal && (ir_q[15:12] == OpBez);

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    issue_cnt_d   = (&issue_cnt_q) ? issue_cnt_q : issue_cnt_q + CNT_W'(1);
    illegal_cnt_d = (&illegal_cnt_q) ? illegal_cnt_q : illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= PC_W'(RESET_PC);
      iss_pc_q      <= '0;
      ir_q          <= '0;
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (!halt) state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            ir_q     <= imem_rdata;
            iss_pc_q <= pc_q;
            pc_q     <= pc_q + PC_W'(1);
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (iss_ready) begin
            issue_cnt_q <= issue_cnt_d;
            if (!ir_legal) illegal_cnt_q <= illegal_cnt_d;
            state_q <= ir_is_bez ? StBranch : StFetch;
          end
        end
        StBranch: begin
          // pc_q already holds the fall-through address.
          if (br_valid) begin
            if (br_taken) pc_q <= br_target;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign imem_req    = (state_q == StFetch) && !halt && !rst;
  assign imem_addr   = pc_q;
  assign iss_valid   = (state_q == StIssue);
  assign iss_illegal = iss_valid && !ir_legal;
  assign iss_opcode  = ir_legal ? ir_q[15:12] : 4'h0;
  assign iss_rd      = ir_q[11:8];
  assign iss_rs      = ir_q[7:4];
  assign iss_rt      = ir_q[3:0];
  assign iss_pc      = iss_pc_q;
  assign issue_cnt   = issue_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
